// File: rtl/rv32i_pkg.sv
// Shared rv32i types: opcode/funct3 encodings, fetch FSM states and the fetch buffer entry.
package rv32i_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    typedef enum logic [6:0] {
        LOAD   = 7'd3,
        OP_IMM = 7'd19,
        STORE  = 7'd35,
        OP     = 7'd51
    } instr_type_t;

    typedef enum logic [2:0] {
        F_ADD_SUB = 3'd0,
        F_SLL     = 3'd1,
        F_SLT     = 3'd2,
        F_SLTU    = 3'd3,
        F_XOR     = 3'd4,
        F_SRL_SRA = 3'd5,
        F_OR      = 3'd6,
        F_AND     = 3'd7
    } func_code_t;

    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    // Only the subset control_unit executes is legal; OP also needs a known funct7.
    function automatic logic is_illegal(input logic [ILEN-1:0] w);
        case (w[6:0])
            LOAD, OP_IMM, STORE: return 1'b0;
            OP:                  return !(w[31:25] == 7'h00 || w[31:25] == 7'h20);
            default:             return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_fetch_unit_if.sv
// Fetch unit bus bundle: imem request/response, redirect and the decode channel.
interface rv32i_fetch_unit_if;
    import rv32i_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [ILEN-1:0] imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            dec_valid;
    logic            dec_ready;
    logic [XLEN-1:0] dec_pc;
    instr_type_t     dec_instr_type;
    func_code_t      dec_func_code;
    logic            dec_funct7b5;
    logic [4:0]      dec_rd;
    logic [4:0]      dec_rs1;
    logic [4:0]      dec_rs2;
    logic            dec_illegal;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc, dec_ready,
        output dec_valid, dec_pc, dec_instr_type, dec_func_code, dec_funct7b5,
        output dec_rd, dec_rs1, dec_rs2, dec_illegal
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc, dec_ready,
        input  dec_valid, dec_pc, dec_instr_type, dec_func_code, dec_funct7b5,
        input  dec_rd, dec_rs1, dec_rs2, dec_illegal
    );

endinterface

// File: rtl/rv32i_fetch_fifo.sv
// Synchronous {pc, instr} buffer with flush; push and pop may share a cycle at any fill level.
module rv32i_fetch_fifo
    import rv32i_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  fetch_entry_t             din,
    input  logic                     pop,
    output fetch_entry_t             dout,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wptr, rptr;
    fetch_entry_t  mem [DEPTH];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= din;
    end

    assign dout  = mem[rptr];
    assign empty = (count == '0);

endmodule

// File: rtl/rv32i_fetch_unit.sv
// rv32i fetch/pre-decode: credit-limited in-order imem fetch, instruction buffer, field slicing,
// and redirect with drain of stale in-flight responses.
module rv32i_fetch_unit
    import rv32i_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rv32i_fetch_unit_if.master   bus
);

    localparam int CW = $clog2(FIFO_DEPTH);

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic [CW:0]     inflight, drop, drop_nxt, inflight_rsp, fifo_count;
    logic [CW+1:0]   used;
    logic            req_fire, rsp_keep, rsp_drop, pop, fifo_empty;
    logic [XLEN-1:0] rsp_pc;
    fetch_entry_t    fifo_dout, head;
    logic            unused_rpc_lsb;

    assign unused_rpc_lsb = ^bus.redirect_pc[1:0];

    assign used               = {1'b0, inflight} + {1'b0, fifo_count};
    assign bus.imem_req_valid = rst_n && (state == FETCH) && !bus.redirect_valid
                                && (used < (CW+2)'(FIFO_DEPTH));
    assign bus.imem_req_addr  = pc;
    assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

    assign rsp_drop     = bus.imem_rsp_valid && (drop != '0);
    assign rsp_keep     = bus.imem_rsp_valid && (drop == '0);
    assign drop_nxt     = drop - {{CW{1'b0}}, rsp_drop};
    assign inflight_rsp = inflight - {{CW{1'b0}}, bus.imem_rsp_valid};

    // Responses are in order, so the oldest outstanding request sits inflight words behind pc.
    assign rsp_pc = pc - {{(XLEN-CW-3){1'b0}}, inflight, 2'b00};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
            state    <= FETCH;
        end else begin
            inflight <= inflight_rsp + {{CW{1'b0}}, req_fire};
            if (bus.redirect_valid) begin
                // Any response arriving now is lost to the flush, so it no longer needs dropping.
                pc    <= {bus.redirect_pc[XLEN-1:2], 2'b00};
                drop  <= inflight_rsp;
                state <= (inflight_rsp != '0) ? DRAIN : FETCH;
            end else begin
                if (req_fire) pc <= pc + 32'd4;
                drop <= drop_nxt;
                if (state == DRAIN && drop_nxt == '0) state <= FETCH;
            end
        end
    end

    assign pop = bus.dec_valid && bus.dec_ready;

    rv32i_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (bus.redirect_valid),
        .push  (rsp_keep),
        .din   ('{pc: rsp_pc, instr: bus.imem_rsp_data}),
        .pop   (pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Head is zeroed when empty so every decode output idles at 0.
    assign head               = fifo_empty ? '0 : fifo_dout;
    assign bus.dec_valid      = !fifo_empty;
    assign bus.dec_pc         = head.pc;
    assign bus.dec_instr_type = instr_type_t'(head.instr[6:0]);
    assign bus.dec_func_code  = func_code_t'(head.instr[14:12]);
    assign bus.dec_funct7b5   = head.instr[30];
    assign bus.dec_rd         = head.instr[11:7];
    assign bus.dec_rs1        = head.instr[19:15];
    assign bus.dec_rs2        = head.instr[24:20];
    assign bus.dec_illegal    = !fifo_empty && is_illegal(head.instr);

endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// Bench for rv32i_fetch_unit: queue-based imem/buffer model, directed scenarios then random traffic.
module tb_rv32i_fetch_unit;
    import rv32i_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rv32i_fetch_unit_if bus ();
    rv32i_fetch_unit_if wbus ();

    rv32i_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
    rv32i_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(2)) u_wrap (
        .clk(clk), .rst_n(rst_n), .bus(wbus));

    typedef struct {
        logic [31:0] addr;
        int          rdy;
        bit          stale;
    } req_t;

    int ncmp = 0, nbad = 0;
    req_t        outq[$];
    logic [31:0] fifoq[$];
    logic [31:0] popped[$];
    logic [31:0] m_pc, last_pop, first_after;
    int          cyc = 0, act_req = 0;
    int          p_rdy = 100, p_drdy = 0, dly_min = 0, dly_max = 0, p_redir = 0;
    bit          hash_mode = 0, redir_req = 0, redir_pp = 0, fresh = 1;
    bit          seen_sra = 0, seen_bad = 0;
    logic [31:0] redir_tgt, exp_first = 32'h0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nbad++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [31:0] h;
        logic [6:0]  ops [5];
        ops = '{7'd3, 7'd19, 7'd35, 7'd51, 7'h7f};
        if (a == 32'h10) return 32'h4000_50b3;
        if (a == 32'h14) return 32'h0000_007f;
        if (!hash_mode)  return 32'h0000_0013;
        h = (a * 32'h9E37_79B9) ^ 32'h5BD1_E995;
        return {h[31:7], ops[h[10:8] % 5]};
    endfunction

    function automatic bit exp_illegal(input logic [31:0] w);
        if (w[6:0] == 7'd3 || w[6:0] == 7'd19 || w[6:0] == 7'd35) return 1'b0;
        if (w[6:0] == 7'd51) return !(w[31:25] == 7'h00 || w[31:25] == 7'h20);
        return 1'b1;
    endfunction

    function automatic int n_stale();
        int n = 0;
        foreach (outq[i]) if (outq[i].stale) n++;
        return n;
    endfunction

    // One clock: drive inputs, check outputs against the model, then advance the model at the edge.
    task automatic cycle();
        bit rsp_now, redir, exp_rv, pop_now, req_now;
        logic [31:0] tgt, w, act_pc;
        req_t e;
        rsp_now = outq.size() > 0 && outq[0].rdy <= cyc;
        bus.imem_rsp_valid = rsp_now;
        bus.imem_rsp_data  = rsp_now ? word_at(outq[0].addr) : $urandom;
        bus.imem_req_ready = ($urandom_range(99) < p_rdy);
        bus.dec_ready      = ($urandom_range(99) < p_drdy);
        redir = redir_req || ($urandom_range(999) < p_redir)
                || (redir_pp && rsp_now && fifoq.size() > 0 && bus.dec_ready && n_stale() == 0);
        if (redir) redir_pp = 0;
        tgt = redir_req ? redir_tgt : $urandom;
        redir_req = 0;
        bus.redirect_valid = redir;
        bus.redirect_pc    = tgt;
        #1;
        exp_rv = !redir && n_stale() == 0 && (outq.size() + fifoq.size() < 2);
        chk("req_valid", bus.imem_req_valid, exp_rv);
        if (exp_rv) chk("req_addr", bus.imem_req_addr, m_pc);
        chk("dec_valid", bus.dec_valid, fifoq.size() != 0);
        if (fifoq.size() != 0) begin
            w = word_at(fifoq[0]);
            chk("dec_pc", bus.dec_pc, fifoq[0]);
            chk("instr_type", bus.dec_instr_type, w[6:0]);
            chk("func_code", bus.dec_func_code, w[14:12]);
            chk("funct7b5", bus.dec_funct7b5, w[30]);
            chk("rd", bus.dec_rd, w[11:7]);
            chk("rs1", bus.dec_rs1, w[19:15]);
            chk("rs2", bus.dec_rs2, w[24:20]);
            chk("illegal", bus.dec_illegal, exp_illegal(w));
            if (fifoq[0] == 32'h10 && !seen_sra) begin
                seen_sra = 1;
                chk("sra_type", bus.dec_instr_type, 32'd51);
                chk("sra_func", bus.dec_func_code, 32'd5);
                chk("sra_f7b5", bus.dec_funct7b5, 32'd1);
                chk("sra_rd", bus.dec_rd, 32'd1);
            end
            if (fifoq[0] == 32'h14 && !seen_bad) begin
                seen_bad = 1;
                chk("opc7f_illegal", bus.dec_illegal, 32'd1);
            end
        end
        act_pc  = bus.dec_pc;
        pop_now = fifoq.size() > 0 && bus.dec_ready && !redir;
        req_now = exp_rv && bus.imem_req_ready;
        if (bus.imem_req_valid && bus.imem_req_ready) act_req++;
        @(posedge clk);
        if (pop_now) begin
            void'(fifoq.pop_front());
            if (fresh) begin
                chk("pop_after_redirect", act_pc, exp_first);
                first_after = act_pc;
                fresh = 0;
            end else begin
                chk("pop_seq_plus4", act_pc, last_pop + 32'd4);
            end
            last_pop = act_pc;
            popped.push_back(act_pc);
        end
        if (rsp_now) begin
            e = outq.pop_front();
            if (!e.stale && !redir) fifoq.push_back(e.addr);
        end
        if (redir) begin
            fifoq.delete();
            foreach (outq[i]) outq[i].stale = 1;
            m_pc = {tgt[31:2], 2'b00};
            exp_first = m_pc;
            fresh = 1;
        end
        if (req_now) begin
            outq.push_back('{m_pc, cyc + 1 + dly_min + $urandom_range(dly_max - dly_min), 1'b0});
            m_pc = m_pc + 32'd4;
        end
        cyc++;
        #1;
    endtask

    initial begin
        bit done;
        bus.imem_req_ready = 0; bus.imem_rsp_valid = 0; bus.imem_rsp_data = '0;
        bus.redirect_valid = 0; bus.redirect_pc = '0; bus.dec_ready = 0;
        wbus.imem_req_ready = 1; wbus.imem_rsp_valid = 0; wbus.imem_rsp_data = '0;
        wbus.redirect_valid = 0; wbus.redirect_pc = '0; wbus.dec_ready = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_valid", bus.imem_req_valid, 32'd0);
        chk("rst_req_addr", bus.imem_req_addr, 32'h0);
        chk("rst_dec_valid", bus.dec_valid, 32'd0);
        chk("rst_dec_pc", bus.dec_pc, 32'd0);
        chk("rst_instr_type", bus.dec_instr_type, 32'd0);
        chk("rst_illegal", bus.dec_illegal, 32'd0);
        chk("rst_wrap_addr", wbus.imem_req_addr, 32'hFFFF_FFFC);

        rst_n = 1; m_pc = 32'h0;
        #1;
        chk("wrap_valid0", wbus.imem_req_valid, 32'd1);
        chk("wrap_addr0", wbus.imem_req_addr, 32'hFFFF_FFFC);

        // Stall decode: exactly two fetches then credit runs out.
        cycle();
        chk("wrap_valid1", wbus.imem_req_valid, 32'd1);
        chk("wrap_addr1", wbus.imem_req_addr, 32'h0);
        repeat (10) cycle();
        chk("stall_req_count", act_req, 32'd2);
        chk("stall_req_valid", bus.imem_req_valid, 32'd0);
        chk("stall_dec_valid", bus.dec_valid, 32'd1);
        chk("stall_dec_pc", bus.dec_pc, 32'h0);
        chk("stall_type", bus.dec_instr_type, 32'd19);
        chk("stall_func", bus.dec_func_code, 32'd0);
        chk("stall_illegal", bus.dec_illegal, 32'd0);

        p_drdy = 100;
        for (int i = 0; i < 60 && popped.size() < 8; i++) cycle();
        chk("drain_pop_count", popped.size() >= 8, 32'd1);
        if (popped.size() >= 3) begin
            chk("pop0", popped[0], 32'h0);
            chk("pop1", popped[1], 32'h4);
            chk("pop2", popped[2], 32'h8);
        end
        chk("saw_sra", seen_sra, 32'd1);
        chk("saw_illegal", seen_bad, 32'd1);

        // Redirect with two fetches outstanding.
        dly_min = 4; dly_max = 4;
        done = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            if (outq.size() == 2 && n_stale() == 0) done = 1;
            else cycle();
        end
        chk("two_inflight_reached", done, 32'd1);
        redir_req = 1; redir_tgt = 32'h0000_0103;
        cycle();
        bus.redirect_valid = 0;
        #1;
        chk("redir_addr", bus.imem_req_addr, 32'h100);
        chk("redir_drain_valid", bus.imem_req_valid, 32'd0);
        for (int i = 0; i < 80 && fresh; i++) cycle();
        chk("redir_first_popped", fresh, 32'd0);
        chk("redir_first_pc", first_after, 32'h100);

        // Redirect colliding with a push and a pop.
        dly_min = 0; dly_max = 0; redir_pp = 1;
        for (int i = 0; i < 60 && redir_pp; i++) cycle();
        chk("pushpop_redir_hit", redir_pp, 32'd0);
        bus.redirect_valid = 0;
        #1;
        chk("pushpop_flush", bus.dec_valid, 32'd0);
        repeat (10) cycle();

        hash_mode = 1;
        for (int s = 0; s < 30; s++) begin
            p_rdy   = $urandom_range(100, 30);
            p_drdy  = $urandom_range(100, 20);
            dly_min = $urandom_range(2);
            dly_max = dly_min + $urandom_range(3);
            p_redir = 30;
            repeat (40) cycle();
        end
        p_redir = 0; p_drdy = 100; p_rdy = 100;
        repeat (30) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

endmodule
